// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: read-return owner tag,
// arbitration FSM states and default sizing constants.
package BasicTypes;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PIPE,
        OWN_DBG
    } owner_e;

    typedef enum logic [1:0] {
        ST_PIPE,
        ST_DBG_ONE,
        ST_DBG_LOCK
    } arb_state_e;

    localparam int LINE_W_DEFAULT     = 14;
    localparam int STARVE_MAX_DEFAULT = 8;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter between the pipeline and a loader/debug
// requester, with starvation forcing, locked debug bursts and read-return routing.
module dmem_port_arbiter
    import BasicTypes::*;
#(
    parameter int LINE_W     = LINE_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipeReq,
    input  logic [3:0]        pipeWe,
    input  logic [LINE_W-1:0] pipeLine,
    input  logic [31:0]       pipeWData,
    output logic              pipeStall,
    output logic [31:0]       pipeRData,
    output logic              pipeRValid,
    input  logic              dbgReq,
    input  logic              dbgLock,
    input  logic [3:0]        dbgWe,
    input  logic [LINE_W-1:0] dbgLine,
    input  logic [31:0]       dbgWData,
    output logic              dbgGnt,
    output logic [31:0]       dbgRData,
    output logic              dbgRValid,
    output logic [3:0]        memWe,
    output logic [LINE_W-1:0] memLine,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    owner_e            owner_q, owner_d;

    logic              grant_pipe;
    logic              grant_dbg;
    logic              stall_raw;
    logic [3:0]        we_raw;
    logic [LINE_W-1:0] line_raw;
    logic [31:0]       wdata_raw;

    always_comb begin
        state_d    = state_q;
        starve_d   = '0;
        grant_pipe = 1'b0;
        grant_dbg  = 1'b0;
        stall_raw  = 1'b0;

        case (state_q)
            ST_PIPE: begin
                if (pipeReq) begin
                    grant_pipe = 1'b1;
                    if (dbgReq) begin
                        starve_d = (starve_q == STARVE_LIM) ? starve_q
                                                            : starve_q + CNT_W'(1);
                        if (starve_d == STARVE_LIM) begin
                            state_d = dbgLock ? ST_DBG_LOCK : ST_DBG_ONE;
                        end
                    end
                end else if (dbgReq) begin
                    grant_dbg = 1'b1;
                    if (dbgLock) begin
                        state_d = ST_DBG_LOCK;
                    end
                end
            end
            ST_DBG_ONE: begin
                grant_dbg = 1'b1;
                stall_raw = pipeReq;
                state_d   = ST_PIPE;
            end
            ST_DBG_LOCK: begin
                grant_dbg = dbgReq;
                stall_raw = pipeReq;
                if (!dbgLock) begin
                    state_d = ST_PIPE;
                end
            end
            default: begin
                state_d = ST_PIPE;
            end
        endcase
    end

    // Idle cycles park the address/data buses at zero so the memory sees a quiet port.
    always_comb begin
        we_raw    = '0;
        line_raw  = '0;
        wdata_raw = '0;
        owner_d   = OWN_NONE;
        if (grant_pipe) begin
            we_raw    = pipeWe;
            line_raw  = pipeLine;
            wdata_raw = pipeWData;
            owner_d   = (pipeWe == 4'h0) ? OWN_PIPE : OWN_NONE;
        end else if (grant_dbg) begin
            we_raw    = dbgWe;
            line_raw  = dbgLine;
            wdata_raw = dbgWData;
            owner_d   = (dbgWe == 4'h0) ? OWN_DBG : OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_PIPE;
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Strobes are masked by reset so nothing reaches memory or requesters while held.
    assign pipeStall  = rst & stall_raw;
    assign dbgGnt     = rst & grant_dbg;
    assign memWe      = rst ? we_raw : 4'h0;
    assign memLine    = line_raw;
    assign memWData   = wdata_raw;

    assign pipeRValid = (owner_q == OWN_PIPE);
    assign dbgRValid  = (owner_q == OWN_DBG);
    assign pipeRData  = memRData;
    assign dbgRData   = memRData;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a behavioural model of who owns the
// port each cycle, a reference memory, and directed scenarios with literal checks.
module tb_dmem_port_arbiter;

    localparam int LW    = 14;
    localparam int SMAX  = 8;
    localparam int DEPTH = 1 << LW;

    localparam int MODE_PIPE   = 0;
    localparam int MODE_FORCED = 1;
    localparam int MODE_BURST  = 2;

    localparam int WHO_NONE = 0;
    localparam int WHO_PIPE = 1;
    localparam int WHO_DBG  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipeReq = 1'b0;
    logic [3:0]    pipeWe = 4'h0;
    logic [LW-1:0] pipeLine = '0;
    logic [31:0]   pipeWData = '0;
    logic          pipeStall;
    logic [31:0]   pipeRData;
    logic          pipeRValid;
    logic          dbgReq = 1'b0;
    logic          dbgLock = 1'b0;
    logic [3:0]    dbgWe = 4'h0;
    logic [LW-1:0] dbgLine = '0;
    logic [31:0]   dbgWData = '0;
    logic          dbgGnt;
    logic [31:0]   dbgRData;
    logic          dbgRValid;
    logic [3:0]    memWe;
    logic [LW-1:0] memLine;
    logic [31:0]   memWData;
    logic [31:0]   memRData = '0;

    int assertCount = 0;
    int failCount   = 0;
    bit checking    = 1'b0;

    logic [31:0] mem    [DEPTH];
    logic [31:0] refMem [DEPTH];

    int          modelMode = MODE_PIPE;
    int          denials   = 0;
    int          pendOwner = WHO_NONE;
    logic [31:0] pendData  = '0;

    typedef struct {
        int            who;
        bit            stall;
        logic [3:0]    we;
        logic [LW-1:0] line;
        logic [31:0]   wdata;
        int            nextMode;
        int            nextDen;
    } pred_t;

    dmem_port_arbiter #(.LINE_W(LW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipeReq(pipeReq), .pipeWe(pipeWe), .pipeLine(pipeLine), .pipeWData(pipeWData),
        .pipeStall(pipeStall), .pipeRData(pipeRData), .pipeRValid(pipeRValid),
        .dbgReq(dbgReq), .dbgLock(dbgLock), .dbgWe(dbgWe), .dbgLine(dbgLine),
        .dbgWData(dbgWData), .dbgGnt(dbgGnt), .dbgRData(dbgRData), .dbgRValid(dbgRValid),
        .memWe(memWe), .memLine(memLine), .memWData(memWData), .memRData(memRData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 32'hA500_0000 | i;
            refMem[i] = 32'hA500_0000 | i;
        end
    end

    // Synchronous-read memory behind the arbiter, one cycle of read latency.
    always @(posedge clk) begin
        memRData <= mem[memLine];
        if (memWe != 4'h0) mem[memLine] <= mergeBytes(mem[memLine], memWData, memWe);
    end

    // Who must own the port this cycle, given the model's mode and the live requests.
    function automatic pred_t predict();
        pred_t p;
        p.who = WHO_NONE;
        p.stall = 1'b0;
        p.nextMode = modelMode;
        p.nextDen = 0;
        if (modelMode == MODE_FORCED) begin
            p.who = WHO_DBG;
            p.stall = pipeReq;
            p.nextMode = MODE_PIPE;
        end else if (modelMode == MODE_BURST) begin
            p.who = dbgReq ? WHO_DBG : WHO_NONE;
            p.stall = pipeReq;
            p.nextMode = dbgLock ? MODE_BURST : MODE_PIPE;
        end else if (pipeReq) begin
            p.who = WHO_PIPE;
            if (dbgReq) begin
                p.nextDen = (denials + 1 > SMAX) ? SMAX : denials + 1;
                if (p.nextDen == SMAX) p.nextMode = dbgLock ? MODE_BURST : MODE_FORCED;
            end
        end else if (dbgReq) begin
            p.who = WHO_DBG;
            p.nextMode = dbgLock ? MODE_BURST : MODE_PIPE;
        end
        p.we    = (p.who == WHO_PIPE) ? pipeWe    : (p.who == WHO_DBG) ? dbgWe    : 4'h0;
        p.line  = (p.who == WHO_PIPE) ? pipeLine  : (p.who == WHO_DBG) ? dbgLine  : '0;
        p.wdata = (p.who == WHO_PIPE) ? pipeWData : (p.who == WHO_DBG) ? dbgWData : '0;
        return p;
    endfunction

    // Model state advances on the same edges as the design, reset included.
    always @(posedge clk or negedge rst) begin
        pred_t p;
        if (!rst) begin
            modelMode <= MODE_PIPE;
            denials   <= 0;
            pendOwner <= WHO_NONE;
        end else begin
            p = predict();
            modelMode <= p.nextMode;
            denials   <= p.nextDen;
            pendOwner <= (p.who != WHO_NONE && p.we == 4'h0) ? p.who : WHO_NONE;
            pendData  <= refMem[p.line];
            if (p.who != WHO_NONE && p.we != 4'h0)
                refMem[p.line] <= mergeBytes(refMem[p.line], p.wdata, p.we);
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        pred_t p;
        if (checking) begin
            if (!rst) begin
                checkOutput("rst_stall", {31'b0, pipeStall}, 32'd0);
                checkOutput("rst_gnt", {31'b0, dbgGnt}, 32'd0);
                checkOutput("rst_we", {28'b0, memWe}, 32'd0);
                checkOutput("rst_pvalid", {31'b0, pipeRValid}, 32'd0);
                checkOutput("rst_dvalid", {31'b0, dbgRValid}, 32'd0);
            end else begin
                p = predict();
                checkOutput("model_stall", {31'b0, pipeStall}, {31'b0, p.stall});
                checkOutput("model_gnt", {31'b0, dbgGnt}, {31'b0, p.who == WHO_DBG});
                checkOutput("model_we", {28'b0, memWe}, {28'b0, p.we});
                if (p.who != WHO_NONE) begin
                    checkOutput("model_line", {18'b0, memLine}, {18'b0, p.line});
                    checkOutput("model_wdata", memWData, p.wdata);
                end
                checkOutput("model_pvalid", {31'b0, pipeRValid}, {31'b0, pendOwner == WHO_PIPE});
                checkOutput("model_dvalid", {31'b0, dbgRValid}, {31'b0, pendOwner == WHO_DBG});
                if (pendOwner == WHO_PIPE) checkOutput("model_prdata", pipeRData, pendData);
                if (pendOwner == WHO_DBG)  checkOutput("model_drdata", dbgRData, pendData);
            end
            checkOutput("prdata_pass", pipeRData, memRData);
            checkOutput("drdata_pass", dbgRData, memRData);
        end
    end

    // One clock cycle of stimulus: drive just after the rising edge, return at the falling edge.
    task automatic applyStimulus(bit r, bit pr, logic [3:0] pw, int pl, logic [31:0] pd,
                                 bit dr, bit dl, logic [3:0] dw, int dln, logic [31:0] dd);
        @(posedge clk);
        #1;
        rst       = r;
        pipeReq   = pr;
        pipeWe    = pw;
        pipeLine  = LW'(pl);
        pipeWData = pd;
        dbgReq    = dr;
        dbgLock   = dl;
        dbgWe     = dw;
        dbgLine   = LW'(dln);
        dbgWData  = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1, 0, 4'h0, 0, 32'h0, 0, 0, 4'h0, 0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checking = 1'b1;

        // Reset held with active requests: nothing may leak out.
        applyStimulus(0, 1, 4'hF, 5, 32'h1111_1111, 1, 0, 4'hF, 6, 32'h2222_2222);
        checkOutput("lit_rst_we", {28'b0, memWe}, 32'd0);
        checkOutput("lit_rst_gnt", {31'b0, dbgGnt}, 32'd0);
        applyStimulus(0, 1, 4'hF, 5, 32'h1111_1111, 1, 0, 4'hF, 6, 32'h2222_2222);
        idle();

        // Lone pipeline read, data one cycle later.
        applyStimulus(1, 1, 4'h0, 'h10, 32'h0, 0, 0, 4'h0, 0, 32'h0);
        checkOutput("lit_pread_we", {28'b0, memWe}, 32'd0);
        checkOutput("lit_pread_line", {18'b0, memLine}, 32'h10);
        idle();
        checkOutput("lit_pread_valid", {31'b0, pipeRValid}, 32'd1);
        checkOutput("lit_pread_data", pipeRData, 32'hA500_0010);

        // Partial pipeline write then read-back.
        applyStimulus(1, 1, 4'h3, 'h20, 32'h1234_5678, 0, 0, 4'h0, 0, 32'h0);
        applyStimulus(1, 1, 4'h0, 'h20, 32'h0, 0, 0, 4'h0, 0, 32'h0);
        checkOutput("lit_pwrite_novalid", {31'b0, pipeRValid}, 32'd0);
        idle();
        checkOutput("lit_pwrite_data", pipeRData, 32'hA500_5678);

        // Starvation: 8 denials, forced single debug read on the 9th cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 4'h0, 'h40, 32'h0, 1, 0, 4'h0, 'h30, 32'h0);
            checkOutput("lit_starve_deny", {31'b0, dbgGnt}, 32'd0);
        end
        applyStimulus(1, 1, 4'h0, 'h40, 32'h0, 1, 0, 4'h0, 'h30, 32'h0);
        checkOutput("lit_starve_gnt", {31'b0, dbgGnt}, 32'd1);
        checkOutput("lit_starve_stall", {31'b0, pipeStall}, 32'd1);
        applyStimulus(1, 1, 4'h0, 'h40, 32'h0, 1, 0, 4'h0, 'h30, 32'h0);
        checkOutput("lit_starve_back", {31'b0, dbgGnt}, 32'd0);
        checkOutput("lit_starve_nostall", {31'b0, pipeStall}, 32'd0);
        checkOutput("lit_starve_dvalid", {31'b0, dbgRValid}, 32'd1);
        checkOutput("lit_starve_ddata", dbgRData, 32'hA500_0030);
        idle();

        // Locked burst entered on an idle pipeline, then four writes under pipeline pressure.
        applyStimulus(1, 0, 4'h0, 0, 32'h0, 1, 1, 4'h0, 'h3F, 32'h0);
        checkOutput("lit_lock_entry_gnt", {31'b0, dbgGnt}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 4'h0, 'h41, 32'h0, 1, 1, 4'hF, k, 32'hD0D0_0000 + k);
            checkOutput("lit_lock_stall", {31'b0, pipeStall}, 32'd1);
            checkOutput("lit_lock_we", {28'b0, memWe}, 32'hF);
            checkOutput("lit_lock_line", {18'b0, memLine}, k);
            if (k == 0) checkOutput("lit_lock_entry_data", dbgRData, 32'hA500_003F);
        end
        applyStimulus(1, 1, 4'h0, 'h41, 32'h0, 0, 1, 4'h0, 0, 32'h0);
        checkOutput("lit_lock_idle_we", {28'b0, memWe}, 32'd0);
        checkOutput("lit_lock_idle_stall", {31'b0, pipeStall}, 32'd1);
        applyStimulus(1, 1, 4'h0, 'h41, 32'h0, 0, 0, 4'h0, 0, 32'h0);
        checkOutput("lit_lock_release_stall", {31'b0, pipeStall}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) applyStimulus(1, 1, 4'h0, k, 32'h0, 0, 0, 4'h0, 0, 32'h0);
            else       idle();
            if (k == 0) checkOutput("lit_lock_resume", {31'b0, pipeStall}, 32'd0);
            if (k > 0)  checkOutput("lit_lock_readback", pipeRData, 32'hD0D0_0000 + k - 1);
        end

        // Back-to-back pipe read then debug read.
        applyStimulus(1, 1, 4'h0, 'h11, 32'h0, 0, 0, 4'h0, 0, 32'h0);
        applyStimulus(1, 0, 4'h0, 0, 32'h0, 1, 0, 4'h0, 'h12, 32'h0);
        checkOutput("lit_b2b_pvalid", {31'b0, pipeRValid}, 32'd1);
        checkOutput("lit_b2b_dvalid0", {31'b0, dbgRValid}, 32'd0);
        checkOutput("lit_b2b_pdata", pipeRData, 32'hA500_0011);
        idle();
        checkOutput("lit_b2b_dvalid", {31'b0, dbgRValid}, 32'd1);
        checkOutput("lit_b2b_pvalid0", {31'b0, pipeRValid}, 32'd0);
        checkOutput("lit_b2b_ddata", dbgRData, 32'hA500_0012);

        // Reset pulse in the middle of a locked burst with a debug read outstanding.
        applyStimulus(1, 0, 4'h0, 0, 32'h0, 1, 1, 4'hF, 'h50, 32'hCAFE_0000);
        applyStimulus(1, 1, 4'h0, 'h42, 32'h0, 1, 1, 4'h0, 'h14, 32'h0);
        checkOutput("lit_mid_stall", {31'b0, pipeStall}, 32'd1);
        applyStimulus(0, 1, 4'h0, 'h42, 32'h0, 1, 1, 4'h0, 'h14, 32'h0);
        checkOutput("lit_abort_dvalid", {31'b0, dbgRValid}, 32'd0);
        checkOutput("lit_abort_stall", {31'b0, pipeStall}, 32'd0);
        checkOutput("lit_abort_gnt", {31'b0, dbgGnt}, 32'd0);
        applyStimulus(0, 1, 4'h0, 'h42, 32'h0, 1, 1, 4'h0, 'h14, 32'h0);
        idle();
        checkOutput("lit_post_dvalid", {31'b0, dbgRValid}, 32'd0);
        applyStimulus(1, 1, 4'h0, 'h15, 32'h0, 1, 0, 4'h0, 'h16, 32'h0);
        checkOutput("lit_post_pipe_stall", {31'b0, pipeStall}, 32'd0);
        checkOutput("lit_post_pipe_gnt", {31'b0, dbgGnt}, 32'd0);
        idle();
        checkOutput("lit_post_pdata", pipeRData, 32'hA500_0015);
        idle();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 14, word-line address width of the data memory.
REQ-002 SHALL have parameter STARVE_MAX, default 8, number of consecutive debug denials before the debug requester is forced through.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pipeReq, input, 1, pipeline memory-access request this cycle.
REQ-006 SHALL have port pipeWe, input, 4, pipeline byte write enables; all-zero means read.
REQ-007 SHALL have port pipeLine, input, LINE_W, pipeline word-line address.
REQ-008 SHALL have port pipeWData, input, 32, pipeline write data, already byte-lane shifted.
REQ-009 SHALL have port pipeStall, output, 1, request to the pipeline controller to stall the memory-access stage.
REQ-010 SHALL have ports pipeRData, output, 32, and pipeRValid, output, 1: the pipeline's read return.
REQ-011 SHALL have ports dbgReq, input, 1; dbgLock, input, 1; dbgWe, input, 4; dbgLine, input, LINE_W; dbgWData, input, 32: the loader/debug requester.
REQ-012 SHALL have ports dbgGnt, output, 1; dbgRData, output, 32; dbgRValid, output, 1.
REQ-013 SHALL have memory-side ports memWe, output, 4; memLine, output, LINE_W; memWData, output, 32; memRData, input, 32 (synchronous read, 1-cycle latency).

Function
REQ-014 SHALL implement FSM states PIPE (pipeline owns port), DBG_ONE (single forced debug access), DBG_LOCK (debug burst owns port).
REQ-015 In PIPE: pipeReq wins; memory signals driven combinationally from the pipeline; pipeStall=0.
REQ-016 In PIPE with dbgReq=1 and pipeReq=0: debug granted the same cycle; dbgGnt=1; starve counter cleared.
REQ-017 In PIPE with dbgReq=1, pipeReq=1: starve counter increments (saturating at STARVE_MAX); at STARVE_MAX the next state is DBG_ONE, or DBG_LOCK if dbgLock=1.
REQ-018 In PIPE with dbgReq=0: starve counter cleared.
REQ-019 In DBG_ONE: debug drives memory; dbgGnt=1; pipeStall=pipeReq; next state PIPE; counter cleared.
REQ-020 PIPE with a debug grant and dbgLock=1 SHALL enter DBG_LOCK.
REQ-021 In DBG_LOCK: debug drives memory when dbgReq=1, else memWe=0; dbgGnt=dbgReq; pipeStall=pipeReq; leave to PIPE on the cycle after dbgLock=0.
REQ-022 Any cycle without a grant SHALL drive memWe=0; memLine and memWData are don't-care but stable.
REQ-023 Granted read (we==0) SHALL register an owner tag; next cycle memRData routes to the owner with pipeRValid or dbgRValid=1 for exactly one cycle.
REQ-024 Granted writes SHALL produce no RValid.
REQ-025 pipeRData/dbgRData SHALL equal memRData whether or not valid (no extra mux latency).
REQ-026 A simultaneous return of the previous read and a new grant SHALL both proceed (fully pipelined, one access per cycle).

Reset
REQ-027 While rst=0: state=PIPE, starve counter=0, owner tag=none; pipeStall=0, pipeRValid=0, dbgGnt=0, dbgRValid=0, memWe=0.
REQ-028 Reset assertion during DBG_LOCK SHALL abandon the burst; an in-flight read return SHALL be dropped (no RValid).

Structure
REQ-029 The owner enum (NONE, PIPE, DBG) and the FSM state enum SHALL live in the shared BasicTypes package; STARVE_MAX default is a package constant.
REQ-030 SHALL be a single module with no sub-modules; the starve counter is inline.

Verification
REQ-031 Pipe read line 0x10 alone -> memWe=0, memLine=0x10; next cycle pipeRValid=1, pipeRData=memRData.
REQ-032 dbgReq held with pipeReq continuously 1 -> 8 denials, 9th cycle DBG_ONE: dbgGnt=1, pipeStall=1; then back to PIPE.
REQ-033 dbgLock=1 burst of 4 writes (we=0xF, lines 0..3) while pipeReq=1 -> pipeStall=1 for 4+ cycles; memWe=0xF each; PIPE resumes one cycle after dbgLock=0.
REQ-034 Back-to-back pipe read then debug read -> pipeRValid then dbgRValid on consecutive cycles; never both high.
REQ-035 rst pulse low mid-DBG_LOCK with a read outstanding -> all outputs 0 immediately; no RValid after release; state PIPE.
